cacheline_adaptor: RTL and testbench

- Responder on the 256-bit line-level physical-memory interface driven by the cache arbiter.
- Each line read or write is converted into a 4-beat, 64-bit burst on the DRAM-side port; write lines are split into beats and read beats are reassembled into a line.
- Sits between the arbiter's main_pmem_* outputs and the off-chip burst memory model.

---
 rtl/rv32i_types.sv | 11 +
 rtl/cacheline_adaptor_burst_buffer.sv | 44 ++++
 rtl/cacheline_adaptor.sv | 140 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared type and constant package for the rv32i memory subsystem.
// Line and burst types plus the burst geometry used by the cacheline adaptor.
package rv32i_types;

    typedef logic [255:0] cacheline_t;
    typedef logic [63:0]  burst_t;

    localparam int BURST_LEN        = 4;
    localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/cacheline_adaptor_burst_buffer.sv
// burst_buffer: one cacheline register that can be loaded whole or written one beat
// at a time, with a beat-indexed read mux for streaming write beats out.
module burst_buffer
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    localparam int IDX_W      = $clog2(LINE_WIDTH / BURST_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_line,
    input  logic [LINE_WIDTH-1:0]  line_in,
    input  logic                   wr_beat,
    input  logic [IDX_W-1:0]       beat_idx,
    input  logic [BURST_WIDTH-1:0] beat_in,
    output logic [LINE_WIDTH-1:0]  line_out,
    output logic [BURST_WIDTH-1:0] beat_out
);

    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load_line) begin
            line_d = line_in;
        end else if (wr_beat) begin
            line_d[beat_idx*BURST_WIDTH +: BURST_WIDTH] = beat_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_out = line_q;
    assign beat_out = line_q[beat_idx*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts 256-bit line reads/writes into 4-beat 64-bit DRAM bursts.
// Define ADAPTOR_EARLY_RESP_EN to answer reads in the last-beat cycle via a top-beat bypass.
module cacheline_adaptor
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [LINE_WIDTH-1:0]  mem_wdata,
    output logic [LINE_WIDTH-1:0]  mem_rdata,
    output logic                   mem_resp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [ADDR_WIDTH-1:0]  pmem_address,
    output logic [BURST_WIDTH-1:0] pmem_wdata,
    input  logic [BURST_WIDTH-1:0] pmem_rdata,
    input  logic                   pmem_resp
);

    localparam int BURST_LEN = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W     = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    load_line;
    logic                    wr_beat;
    logic                    beat_last;
    logic [LINE_WIDTH-1:0]   line_out;
    logic [BURST_WIDTH-1:0]  beat_out;

    assign beat_last = pmem_resp && (cnt_q == LAST_BEAT);

    burst_buffer #(
        .LINE_WIDTH  (LINE_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_line (load_line),
        .line_in   (mem_wdata),
        .wr_beat   (wr_beat),
        .beat_idx  (cnt_q),
        .beat_in   (pmem_rdata),
        .line_out  (line_out),
        .beat_out  (beat_out)
    );

    // Read wins when both requests are raised together.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        load_line = 1'b0;
        wr_beat   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read) begin
                    addr_d  = mem_address & ~OFFSET_MASK;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end else if (mem_write) begin
                    addr_d    = mem_address & ~OFFSET_MASK;
                    cnt_d     = '0;
                    load_line = 1'b1;
                    state_d   = WR_BURST;
                end
            end
            RD_BURST: begin
                if (pmem_resp) begin
                    wr_beat = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (beat_last) begin
`ifdef ADAPTOR_EARLY_RESP_EN
                        state_d = IDLE;
`else
                        state_d = RD_DONE;
`endif
                    end
                end
            end
            RD_DONE: state_d = IDLE;
            WR_BURST: begin
                if (pmem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) begin
                        state_d = WR_DONE;
                    end
                end
            end
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        pmem_read    = (state_q == RD_BURST);
        pmem_write   = (state_q == WR_BURST);
        pmem_address = addr_q;
        pmem_wdata   = beat_out;
        mem_resp     = (state_q == RD_DONE) || (state_q == WR_DONE);
        mem_rdata    = line_out;
`ifdef ADAPTOR_EARLY_RESP_EN
        // The top beat is not in the buffer yet on the last-beat cycle.
        if ((state_q == RD_BURST) && beat_last) begin
            mem_resp = 1'b1;
            mem_rdata[LINE_WIDTH-1 -: BURST_WIDTH] = pmem_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, stalled writes, back-to-back,
// asynchronous reset mid-burst and the simultaneous read/write request.
module tb_cacheline_adaptor;
    import rv32i_types::*;

`ifdef ADAPTOR_EARLY_RESP_EN
    localparam int RD_RC = 4;
`else
    localparam int RD_RC = 5;
`endif

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    cacheline_t  mem_wdata;
    cacheline_t  mem_rdata;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    burst_t      pmem_wdata;
    burst_t      pmem_rdata;
    logic        pmem_resp;

    int errors = 0;
    int checks = 0;

    cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request starting in the current cycle (cycle 0); bit c of pat is
    // pmem_resp in cycle c. Returns in the mem_resp cycle, request still held.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input cacheline_t wdata, input cacheline_t rline, input logic [31:0] pat,
                       output int rc, output int first_busy, output int busy_cnt,
                       output logic rd_seen, output logic wr_seen, output logic [31:0] addr_seen,
                       output cacheline_t wbeats, output cacheline_t rdata);
        int nb;
        rc = -1; first_busy = -1; busy_cnt = 0; rd_seen = 1'b0; wr_seen = 1'b0;
        addr_seen = '0; wbeats = '0; rdata = '0; nb = 0;
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wdata; pmem_resp = 1'b0;
        #1;
        for (int c = 1; c <= 30 && rc < 0; c++) begin
            tick();
            pmem_resp  = pat[c];
            pmem_rdata = rline[(nb % 4)*64 +: 64];
            #1;
            if (pmem_read || pmem_write) begin
                if (first_busy < 0) first_busy = c;
                busy_cnt++;
                addr_seen = pmem_address;
            end
            rd_seen = rd_seen | pmem_read;
            wr_seen = wr_seen | pmem_write;
            if (pmem_resp && pmem_write) wbeats[(nb % 4)*64 +: 64] = pmem_wdata;
            if (pmem_resp) nb++;
            if (mem_resp) begin
                rc    = c;
                rdata = mem_rdata;
            end
        end
        pmem_resp = 1'b0;
    endtask

    // Initiator drops the request after mem_resp; no second response, no re-service.
    task automatic settle(input string tag);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        chk({tag, ".resp_once"}, mem_resp, 1'b0);
        tick();
        chk({tag, ".no_reissue"}, {pmem_read, pmem_write}, 2'b00);
    endtask

    initial begin
        int         rc, fb, bc;
        logic       rs, ws;
        logic [31:0] as;
        cacheline_t wb, rd;
        cacheline_t line1, wline, line2, line3;

        line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        line2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h0F0F_0F0F_0F0F_0F0F, 64'h5A5A_5A5A_5A5A_5A5A};
        line3 = {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
                 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666};

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
        mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;

        // Reset state
        tick();
        chk("reset.ctrl", {mem_resp, pmem_read, pmem_write}, 3'b000);
        chk("reset.addr", pmem_address, 32'h0);
        chk("reset.rdata", mem_rdata, 256'h0);
        chk("reset.wdata", pmem_wdata, 64'h0);
        tick();
        rst = 1'b0;

        // Read with no stalls
        txn(1'b1, 1'b0, 32'h0000_1234, '0, line1, 32'h0000_001E, rc, fb, bc, rs, ws, as, wb, rd);
        chk("rd.resp_cycle", rc, RD_RC);
        chk("rd.first_busy", fb, 1);
        chk("rd.busy_cycles", bc, 4);
        chk("rd.addr", as, 32'h0000_1220);
        chk("rd.no_write", ws, 1'b0);
        chk("rd.rdata", rd, line1);
        settle("rd");
        chk("rd.rdata_hold", mem_rdata, line1);

        // Write: memory notices the request a cycle late, then 2 wait states per beat
        txn(1'b0, 1'b1, 32'h0000_5678, wline, '0, 32'h0000_2490, rc, fb, bc, rs, ws, as, wb, rd);
        chk("wr.resp_cycle", rc, 14);
        chk("wr.first_busy", fb, 1);
        chk("wr.busy_cycles", bc, 13);
        chk("wr.addr", as, 32'h0000_5660);
        chk("wr.no_read", rs, 1'b0);
        chk("wr.beats", wb, wline);
        settle("wr");

        // Back-to-back: read, then write raised the cycle after the read's mem_resp
        txn(1'b1, 1'b0, 32'h0000_0040, '0, line3, 32'h0000_001E, rc, fb, bc, rs, ws, as, wb, rd);
        chk("b2b.rd_resp_cycle", rc, RD_RC);
        chk("b2b.rd_rdata", rd, line3);
        tick();
        chk("b2b.gap_resp", mem_resp, 1'b0);
        txn(1'b0, 1'b1, 32'h0000_0080, wline, '0, 32'h0000_001E, rc, fb, bc, rs, ws, as, wb, rd);
        chk("b2b.wr_first_busy", fb, 1);
        chk("b2b.wr_resp_cycle", rc, 5);
        chk("b2b.wr_beats", wb, wline);
        settle("b2b");

        // Asynchronous reset after the second beat of a read
        mem_read = 1'b1; mem_address = 32'h8000_0040;
        tick();
        pmem_resp = 1'b1; pmem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
        tick();
        pmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("rstmid.in_burst", pmem_read, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid.ctrl", {mem_resp, pmem_read, pmem_write}, 3'b000);
        chk("rstmid.addr", pmem_address, 32'h0);
        chk("rstmid.rdata", mem_rdata, 256'h0);
        chk("rstmid.wdata", pmem_wdata, 64'h0);
        mem_read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        txn(1'b1, 1'b0, 32'h8000_007F, '0, line2, 32'h0000_001E, rc, fb, bc, rs, ws, as, wb, rd);
        chk("rstmid.rd_resp_cycle", rc, RD_RC);
        chk("rstmid.rd_addr", as, 32'h8000_0060);
        chk("rstmid.rd_rdata", rd, line2);
        settle("rstmid");

        // Read and write raised together
        txn(1'b1, 1'b1, 32'h0000_0ABC, wline, line3, 32'h0000_001E, rc, fb, bc, rs, ws, as, wb, rd);
        chk("both.resp_cycle", rc, RD_RC);
        chk("both.read_seen", rs, 1'b1);
        chk("both.no_write", ws, 1'b0);
        chk("both.addr", as, 32'h0000_0AA0);
        chk("both.rdata", rd, line3);
        settle("both");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
